// File: rtl/tile_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_ram_arbiter_if
// Purpose  : Scan-position, write-request, tile-RAM and pixel-out bundle for
//            the tile RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface tile_ram_arbiter_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        vid_on;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic        ram_we;
    logic [17:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic [11:0] pix_data;
    logic        pix_valid;

    modport slave (
        input  pixel_x, pixel_y, vid_on, wr_req, wr_addr, wr_data, ram_rdata,
        output wr_ack, fifo_full, fifo_empty, overflow,
               ram_we, ram_addr, ram_wdata, pix_data, pix_valid
    );

    modport master (
        output pixel_x, pixel_y, vid_on, wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_ack, fifo_full, fifo_empty, overflow,
               ram_we, ram_addr, ram_wdata, pix_data, pix_valid
    );
endinterface
`default_nettype wire

// File: rtl/tile_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_ram_arbiter
// Purpose  : Shares one tile RAM between the board scan-out and a FIFO of
//            game-logic writes; scan-out reads always win.
// Revision : 1.0 - initial release
// ============================================================================
module tile_ram_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int BOARD_TOP  = 100,
    parameter int BOARD_BOT  = 419
) (
    input  logic              clk,
    input  logic              rst,
    tile_ram_arbiter_if.slave bus
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]         c_TOP   = 10'(BOARD_TOP);
    localparam logic [9:0]         c_BOT   = 10'(BOARD_BOT);

    // Bit 1 of the state is the RAM write strobe, bit 0 marks a scan read.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               w_vw;
    logic [17:0]        w_row;
    logic [17:0]        w_rd_addr;
    logic               w_push;
    logic               w_pop;
    logic [29:0]        w_head;
    logic [c_CNT_W-1:0] w_count_next;

    logic [29:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_fifo_full;
    logic               r_fifo_empty;
    logic               r_overflow;
    logic               r_wr_ack;
    logic [17:0]        r_ram_addr;
    logic [11:0]        r_ram_wdata;
    logic               r_vw_d2;
    logic               r_pix_valid;
    logic [11:0]        r_pix_data;

    assign w_vw      = bus.vid_on && (bus.pixel_y >= c_TOP) && (bus.pixel_y <= c_BOT);
    assign w_row     = 18'(bus.pixel_y) - 18'(c_TOP);
    assign w_rd_addr = (w_row * 18'd640) + 18'(bus.pixel_x);

    // Full is the registered flag, so a push at full is refused even if a pop happens.
    assign w_push = bus.wr_req && !r_fifo_full;
    assign w_pop  = (w_state_next == S_WRITE);
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_state_next = S_IDLE;
        if (w_vw) begin
            w_state_next = S_READ;
        end else if (!r_fifo_empty) begin
            w_state_next = S_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fifo_full  <= 1'b0;
            r_fifo_empty <= 1'b1;
            r_overflow   <= 1'b0;
            r_wr_ack     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count      <= w_count_next;
            r_fifo_full  <= (w_count_next == c_DEPTH);
            r_fifo_empty <= (w_count_next == '0);
            r_wr_ack     <= w_push;
            if (bus.wr_req && r_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // RAM port: idle cycles leave address and data parked on the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_state_next == S_READ) begin
            r_ram_addr <= w_rd_addr;
        end else if (w_state_next == S_WRITE) begin
            r_ram_addr  <= w_head[29:12];
            r_ram_wdata <= w_head[11:0];
        end
    end

    // A READ state at n+1 means VW at n; RAM data for it arrives at n+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vw_d2     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
        end else begin
            r_vw_d2     <= (r_state == S_READ);
            r_pix_valid <= r_vw_d2;
            r_pix_data  <= r_vw_d2 ? bus.ram_rdata : 12'h000;
        end
    end

    assign bus.ram_we     = (r_state == S_WRITE);
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.fifo_full  = r_fifo_full;
    assign bus.fifo_empty = r_fifo_empty;
    assign bus.overflow   = r_overflow;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_data   = r_pix_data;

endmodule
`default_nettype wire

// File: tb/tb_tile_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_ram_arbiter
// Purpose  : Directed and random stimulus against a queue-based reference
//            model of the tile RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_ram_arbiter;

    localparam int DEPTH     = 16;
    localparam int BOARD_TOP = 100;
    localparam int BOARD_BOT = 419;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tile_ram_arbiter_if bus();

    tile_ram_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .BOARD_TOP  (BOARD_TOP),
        .BOARD_BOT  (BOARD_BOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: expected value of every output after each edge.
    logic [29:0] q[$];
    logic        m_we, m_ack, m_ovf, m_pix_valid, m_vw1, m_vw2;
    logic [17:0] m_addr;
    logic [11:0] m_wdata, m_pix_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          vw;
        bit          full_b;
        bit          empty_b;
        logic [29:0] e;
        if (rst) begin
            q.delete();
            m_we = 0; m_ack = 0; m_ovf = 0; m_pix_valid = 0;
            m_vw1 = 0; m_vw2 = 0;
            m_addr = '0; m_wdata = '0; m_pix_data = '0;
            return;
        end
        vw      = bus.vid_on && (int'(bus.pixel_y) >= BOARD_TOP) && (int'(bus.pixel_y) <= BOARD_BOT);
        full_b  = (q.size() == DEPTH);
        empty_b = (q.size() == 0);
        m_pix_valid = m_vw2;
        m_pix_data  = m_vw2 ? bus.ram_rdata : 12'h000;
        m_vw2 = m_vw1;
        m_vw1 = vw;
        if (vw) begin
            m_we   = 0;
            m_addr = 18'((int'(bus.pixel_y) - BOARD_TOP) * 640 + int'(bus.pixel_x));
        end else if (!empty_b) begin
            e       = q.pop_front();
            m_we    = 1;
            m_addr  = e[29:12];
            m_wdata = e[11:0];
        end else begin
            m_we = 0;
        end
        m_ack = 0;
        if (bus.wr_req) begin
            if (!full_b) begin
                q.push_back({bus.wr_addr, bus.wr_data});
                m_ack = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_all();
        check("ram_we",     32'(bus.ram_we),     32'(m_we));
        check("ram_addr",   32'(bus.ram_addr),   32'(m_addr));
        check("ram_wdata",  32'(bus.ram_wdata),  32'(m_wdata));
        check("wr_ack",     32'(bus.wr_ack),     32'(m_ack));
        check("fifo_full",  32'(bus.fifo_full),  32'(q.size() == DEPTH));
        check("fifo_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
        check("overflow",   32'(bus.overflow),   32'(m_ovf));
        check("pix_valid",  32'(bus.pix_valid),  32'(m_pix_valid));
        check("pix_data",   32'(bus.pix_data),   32'(m_pix_data));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        bus.ram_rdata = 12'($urandom);
    endtask

    task automatic drive(input bit vid, input int y, input int x,
                         input bit req, input int addr, input int data);
        bus.vid_on  = vid;
        bus.pixel_y = 10'(y);
        bus.pixel_x = 10'(x);
        bus.wr_req  = req;
        bus.wr_addr = 18'(addr);
        bus.wr_data = 12'(data);
    endtask

    initial begin
        int vid_pct;
        int req_pct;
        n_checks = 0;
        n_errors = 0;
        bus.ram_rdata = 12'h5A5;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // First two board pixels, then flush the pixel pipeline.
        drive(1, 100, 0, 0, 0, 0); step();
        check("addr_row0_px0", 32'(bus.ram_addr), 32'd0);
        drive(1, 100, 1, 0, 0, 0); step();
        check("addr_row0_px1", 32'(bus.ram_addr), 32'd1);
        drive(0, 100, 2, 0, 0, 0);
        repeat (3) step();

        // Last board pixel, then first row below the board.
        drive(1, 419, 639, 0, 0, 0); step();
        check("addr_last_px", 32'(bus.ram_addr), 32'd204799);
        drive(1, 420, 0, 0, 0, 0); step();
        check("below_board_no_read_addr", 32'(bus.ram_addr), 32'd204799);
        drive(0, 420, 0, 0, 0, 0);
        repeat (3) step();

        // Three writes queued during VW, drained in order afterwards.
        drive(1, 200, 10, 1, 5, 12'hF00); step();
        drive(1, 200, 11, 1, 6, 12'h0F0); step();
        drive(1, 200, 12, 1, 7, 12'h00F); step();
        drive(0, 200, 13, 0, 0, 0);
        step();
        check("drain0_we", 32'(bus.ram_we), 32'd1);
        check("drain0_data", 32'(bus.ram_wdata), 32'h0F00);
        repeat (5) step();
        check("drain_done_empty", 32'(bus.fifo_empty), 32'd1);

        // Seventeen writes with VW held: the last one overflows.
        for (int i = 0; i < 17; i++) begin
            drive(1, 150, i, 1, 1000 + i, 12'h100 + i);
            step();
        end
        check("seventeenth_ack", 32'(bus.wr_ack), 32'd0);
        drive(1, 150, 20, 0, 0, 0);
        repeat (2) step();
        check("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Drain interrupted by VW, then resumed.
        drive(0, 150, 0, 0, 0, 0);
        repeat (4) step();
        drive(1, 300, 5, 0, 0, 0);
        repeat (3) step();
        check("vw_blocks_write", 32'(bus.ram_we), 32'd0);
        drive(0, 300, 0, 0, 0, 0);
        repeat (16) step();

        // Reset mid-drain with eight entries queued.
        for (int i = 0; i < 8; i++) begin
            drive(1, 250, i, 1, 2000 + i, 12'h200 + i);
            step();
        end
        drive(0, 250, 0, 0, 0, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("post_rst_no_we", 32'(bus.ram_we), 32'd0);
        repeat (4) step();

        // Randomized segments with varying video duty and request rate.
        for (int s = 0; s < 25; s++) begin
            vid_pct = (s % 4 == 0) ? 0 : (s % 4 == 1) ? 30 : (s % 4 == 2) ? 90 : 100;
            req_pct = int'($urandom_range(90, 10));
            for (int c = 0; c < 40; c++) begin
                drive(($urandom_range(99, 0) < vid_pct) ? 1'b1 : 1'b0,
                      int'($urandom_range(430, 90)), int'($urandom_range(639, 0)),
                      ($urandom_range(99, 0) < req_pct) ? 1'b1 : 1'b0,
                      int'($urandom), int'($urandom));
                rst = ($urandom_range(299, 0) == 0) ? 1'b1 : 1'b0;
                step();
            end
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
